// File: rtl/line_tx_pkg.sv
// line_tx_pkg
// Shared definitions for the line_tx serial transmitter:
//   state_t        - transmitter FSM states
//   MIN_BIT_CYCLES - smallest legal symbol hold time in clocks
//   IDLE_LEVEL     - line level while idle and during the stop symbol
//   START_LEVEL    - line level of the start symbol
package line_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int   MIN_BIT_CYCLES = 4;
    localparam logic IDLE_LEVEL     = 1'b0;
    localparam logic START_LEVEL    = 1'b1;

endpackage

// File: rtl/line_tx_bit_timer.sv
// line_tx_bit_timer
// Symbol-period down-counter for line_tx.
// Ports:
//   clock  - clock, posedge
//   reset  - asynchronous, active-low
//   load   - reload the counter with BIT_CYCLES-1 (start of a new symbol)
//   run    - a symbol is being held; gates tick
//   tick   - high during the last clock of the current symbol
// The counter saturates at zero, so it never wraps inside a symbol; the
// owner reloads it on every symbol boundary.
module line_tx_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= RELOAD;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign tick = run && (cnt_reg == '0);

endmodule

// File: rtl/line_tx.sv
// line_tx
// Serial line transmitter. Accepts DATA_W-bit words over valid/ready and
// sends each as: start symbol (1), data bits LSB first, optional even
// parity bit, stop symbol (0). Every symbol is held BIT_CYCLES clocks so a
// 3-sample majority filter on the receiving side recovers it.
// Build option: define LINE_TX_PARITY_EN to insert the even-parity symbol.
// Ports:
//   clock      - clock, posedge
//   reset      - asynchronous, active-low; aborts any frame in progress
//   data_in    - word to send, captured on an accepted handshake
//   valid_in   - word available
//   ready_out  - idle and out of reset; handshake completes on valid&ready
//   sig_out    - registered serial line, idle level 0
//   frame_done - one-cycle pulse as the line returns to idle after a frame
module line_tx
    import line_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              sig_out,
    output logic              frame_done
);

    generate
        if (BIT_CYCLES < MIN_BIT_CYCLES) begin : g_bit_cycles_check
            $error("line_tx: BIT_CYCLES must be at least %0d", MIN_BIT_CYCLES);
        end
    endgenerate

    localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    state_t                state_reg, state_next;
    logic [DATA_W-1:0]     shift_reg, shift_next;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic                  sig_reg, sig_next;
    logic                  done_reg, done_next;
    logic                  live_reg;
`ifdef LINE_TX_PARITY_EN
    logic                  parity_reg, parity_next;
`endif

    logic accept;
    logic tick;
    logic run;

    // live_reg keeps ready_out low while reset is held and for the edge on
    // which it is released, so the first handshake lands on a clean state.
    assign ready_out = live_reg && (state_reg == IDLE);
    assign accept    = valid_in && ready_out;
    assign run       = (state_reg != IDLE);

    line_tx_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) bit_timer (
        .clock (clock),
        .reset (reset),
        .load  (accept || tick),
        .run   (run),
        .tick  (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            sig_reg     <= IDLE_LEVEL;
            done_reg    <= 1'b0;
            live_reg    <= 1'b0;
`ifdef LINE_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            sig_reg     <= sig_next;
            done_reg    <= done_next;
            live_reg    <= 1'b1;
`ifdef LINE_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    // The line level for each symbol is decided here and registered, so
    // sig_out changes exactly on symbol boundaries with no decode glitches.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        sig_next     = sig_reg;
        done_next    = 1'b0;
`ifdef LINE_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                sig_next = IDLE_LEVEL;
                if (accept) begin
                    state_next   = START;
                    sig_next     = START_LEVEL;
                    shift_next   = data_in;
                    bit_cnt_next = '0;
`ifdef LINE_TX_PARITY_EN
                    parity_next  = ^data_in;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    sig_next   = shift_reg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == LAST_BIT) begin
`ifdef LINE_TX_PARITY_EN
                        state_next = PARITY;
                        sig_next   = parity_reg;
`else
                        state_next = STOP;
                        sig_next   = IDLE_LEVEL;
`endif
                    end else begin
                        shift_next   = shift_reg >> 1;
                        sig_next     = shift_next[0];
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
`ifdef LINE_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    sig_next   = IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                sig_next   = IDLE_LEVEL;
            end
        endcase
    end

    assign sig_out    = sig_reg;
    assign frame_done = done_reg;

endmodule

// File: tb/tb_line_tx.sv
// tb_line_tx
// Scoreboard bench for line_tx (DATA_W=8, BIT_CYCLES=4). The stimulus side
// computes when each frame must start and pushes the hand-written symbol
// sequence into a queue; the monitor pops it when the frame is due and
// checks sig_out, ready_out and frame_done on every falling edge.
// Honours LINE_TX_PARITY_EN in the same way as the design.
module tb_line_tx;

    localparam int DW = 8;
    localparam int B  = 4;
`ifdef LINE_TX_PARITY_EN
    localparam int F = DW + 3;
    // {stop, parity, data[7:0], start}, bit i = symbol i
    localparam logic [15:0] LV_A5 = 16'b00000_0_0_10100101_1;
    localparam logic [15:0] LV_01 = 16'b00000_0_1_00000001_1;
    localparam logic [15:0] LV_FF = 16'b00000_0_0_11111111_1;
    localparam logic [15:0] LV_3C = 16'b00000_0_0_00111100_1;
`else
    localparam int F = DW + 2;
    // {stop, data[7:0], start}, bit i = symbol i
    localparam logic [15:0] LV_A5 = 16'b000000_0_10100101_1;
    localparam logic [15:0] LV_01 = 16'b000000_0_00000001_1;
    localparam logic [15:0] LV_FF = 16'b000000_0_11111111_1;
    localparam logic [15:0] LV_3C = 16'b000000_0_00111100_1;
`endif
    localparam int FL = F * B;

    logic          clock;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic          sig_out;
    logic          frame_done;

    typedef struct {
        int          start;
        logic [15:0] levels;
        int          len;
        bit          done;
    } frame_t;

    frame_t q[$];
    frame_t cur;
    bit     act;
    bit     mon_handled;
    int     mon_off;
    int     cyc;
    int     next_free;
    int     rdy_from;
    bit     in_reset;
    int     checks;
    int     errors;

    line_tx #(
        .DATA_W     (DW),
        .BIT_CYCLES (B)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .sig_out    (sig_out),
        .frame_done (frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", nm, cyc, actual, expected);
        end
    endtask

    // Monitor: compare every cycle against the expected schedule.
    always @(negedge clock) begin
        mon_handled = 1'b0;
        if (!act && q.size() > 0 && q[0].start == cyc) begin
            cur = q.pop_front();
            act = 1'b1;
        end
        if (act) begin
            mon_off = cyc - cur.start;
            if (mon_off < cur.len) begin
                chk("sig_frame", sig_out, cur.levels[mon_off / B]);
                chk("ready_busy", ready_out, 1'b0);
                chk("done_busy", frame_done, 1'b0);
                mon_handled = 1'b1;
            end else begin
                act = 1'b0;
                if (cur.done) begin
                    chk("done_end", frame_done, 1'b1);
                    chk("sig_end", sig_out, 1'b0);
                    chk("ready_end", ready_out, 1'b1);
                    mon_handled = 1'b1;
                end
                $display("rx frame start=%0d cycles=%0d done=%0b errors=%0d",
                         cur.start, cur.len, cur.done, errors);
            end
        end
        if (!mon_handled) begin
            chk("sig_idle", sig_out, 1'b0);
            chk("done_idle", frame_done, 1'b0);
            chk("ready_idle", ready_out, !in_reset && (cyc >= rdy_from));
        end
    end

    // Called between edges with cyc = c; edge c+1 is the first live edge.
    task automatic release_reset();
        reset     = 1'b1;
        in_reset  = 1'b0;
        rdy_from  = cyc + 1;
        next_free = cyc + 2;
    endtask

    // Called at a falling edge. Drives valid/data, predicts the accepting
    // edge, queues the expectation and returns at the falling edge after it.
    task automatic send(input logic [DW-1:0] d, input logic [15:0] lv,
                        input bit keep, input int len, input bit done);
        frame_t f;
        valid_in = 1'b1;
        data_in  = d;
        f.start  = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        f.levels = lv;
        f.len    = len;
        f.done   = done;
        q.push_back(f);
        next_free = f.start + FL + 1;
        $display("tx data=%02h start=%0d", d, f.start);
        while (cyc < f.start) @(negedge clock);
        if (!keep) valid_in = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        in_reset  = 1'b1;
        rdy_from  = 1 << 30;
        next_free = 1 << 30;
        act       = 1'b0;
        checks    = 0;
        errors    = 0;

        repeat (3) @(negedge clock);
        #2;
        chk("sig_rst", sig_out, 1'b0);
        chk("ready_rst", ready_out, 1'b0);
        chk("done_rst", frame_done, 1'b0);
        release_reset();

        // idle after reset
        repeat (11) @(negedge clock);

        // single frame
        send(8'hA5, LV_A5, 1'b0, FL, 1'b1);
        repeat (FL + 3) @(negedge clock);

        // valid held high: back-to-back frames at the minimum period
        send(8'h01, LV_01, 1'b1, FL, 1'b1);
        send(8'hFF, LV_FF, 1'b0, FL, 1'b1);
        repeat (FL + 3) @(negedge clock);

        // data_in and valid_in churn while a frame is in flight
        send(8'h3C, LV_3C, 1'b0, FL, 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            data_in  = DW'($urandom);
            valid_in = 1'($urandom_range(0, 1));
        end
        valid_in = 1'b0;
        repeat (FL) @(negedge clock);

        // reset 15 clocks into a frame: line drops at once, no frame_done
        send(8'hFF, LV_FF, 1'b0, 15, 1'b0);
        repeat (14) @(negedge clock);
        #2;
        reset    = 1'b0;
        in_reset = 1'b1;
        #1;
        chk("sig_async", sig_out, 1'b0);
        chk("ready_async", ready_out, 1'b0);
        repeat (3) @(negedge clock);
        #2;
        release_reset();
        @(negedge clock);

        // clean frame right after release
        send(8'hA5, LV_A5, 1'b0, FL, 1'b1);
        repeat (FL + 3) @(negedge clock);

        chk("scoreboard_empty", (q.size() == 0) && !act, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
